// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard detection and forwarding control for a five-stage MIPS-subset
// pipeline.  It decodes the instruction in D, keeps a small shadow copy of
// the register fields and result timing of the instructions in E, M and W,
// and from those produces the stall request and the operand-source selects
// for the D, E and M stage bypass muxes.  The whole decision is
// combinational; only the shadow registers and the stall counter are state.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   instr_d    in   [31:0] instruction currently in decode
//   stall      out  freeze PC and IF/ID, inject a bubble into ID/EX
//   fwd_rs_d   out  [1:0] D-stage rs source: 0 regfile, 1 E, 2 M, 3 W
//   fwd_rt_d   out  [1:0] D-stage rt source: 0 regfile, 1 E, 2 M, 3 W
//   fwd_rs_e   out  [1:0] E-stage rs source: 0 pipe reg, 1 M, 2 W
//   fwd_rt_e   out  [1:0] E-stage rt source: 0 pipe reg, 1 M, 2 W
//   fwd_rt_m   out  M-stage store data source: 0 pipe reg, 1 W
//   stall_cnt  out  [CNT_W-1:0] saturating count of stalled cycles
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_d,
  output logic             stall,
  output logic [1:0]       fwd_rs_d,
  output logic [1:0]       fwd_rt_d,
  output logic [1:0]       fwd_rs_e,
  output logic [1:0]       fwd_rt_e,
  output logic             fwd_rt_m,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  // ------------------------------------------------------------------
  // D-stage decode
  // ------------------------------------------------------------------
  logic [5:0] op_d;
  logic [5:0] funct_d;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [4:0] rd_d;

  assign op_d    = instr_d[31:26];
  assign rs_d    = instr_d[25:21];
  assign rt_d    = instr_d[20:16];
  assign rd_d    = instr_d[15:11];
  assign funct_d = instr_d[5:0];

  // shamt/immediate middle bits never affect hazard decisions
  logic unused_bits;
  assign unused_bits = ^instr_d[10:6];

  logic is_cal_r;
  logic is_cal_i;
  logic is_ld;
  logic is_st;
  logic is_btype;
  logic is_jr;
  logic is_jal;
  logic is_j;

  always_comb begin
    is_cal_r = 1'b0;
    is_jr    = 1'b0;
    if (op_d == OP_RTYPE) begin
      case (funct_d)
        FN_ADDU, FN_SUBU, FN_SLT, FN_SLL, FN_XOR: is_cal_r = 1'b1;
        FN_JR:                                    is_jr    = 1'b1;
        default: ;
      endcase
    end
    is_cal_i = (op_d == OP_ORI) || (op_d == OP_ADDI) || (op_d == OP_ADDIU) ||
               (op_d == OP_LUI) || (op_d == OP_ANDI);
    is_ld    = (op_d == OP_LW);
    is_st    = (op_d == OP_SW);
    is_btype = (op_d == OP_BEQ);
    is_jal   = (op_d == OP_JAL);
    is_j     = (op_d == OP_J);
  end

  // Destination, result latency and operand need time of the D instruction.
  // j is decoded only so that it is explicitly a no-op for hazards.
  logic [4:0] dst_d;
  logic [1:0] tnew_d;
  logic       use_rs;
  logic [1:0] tuse_rs;
  logic       use_rt;
  logic [1:0] tuse_rt;

  always_comb begin
    dst_d   = 5'd0;
    tnew_d  = 2'd0;
    use_rs  = 1'b0;
    tuse_rs = 2'd0;
    use_rt  = 1'b0;
    tuse_rt = 2'd0;

    if (is_cal_r) begin
      dst_d   = rd_d;
      tnew_d  = 2'd1;
      use_rs  = 1'b1;
      tuse_rs = 2'd1;
      use_rt  = 1'b1;
      tuse_rt = 2'd1;
    end else if (is_cal_i) begin
      dst_d   = rt_d;
      tnew_d  = 2'd1;
      use_rs  = 1'b1;
      tuse_rs = 2'd1;
    end else if (is_ld) begin
      dst_d   = rt_d;
      tnew_d  = 2'd2;
      use_rs  = 1'b1;
      tuse_rs = 2'd1;
    end else if (is_st) begin
      use_rs  = 1'b1;
      tuse_rs = 2'd1;
      use_rt  = 1'b1;
      tuse_rt = 2'd2;
    end else if (is_btype) begin
      use_rs  = 1'b1;
      tuse_rs = 2'd0;
      use_rt  = 1'b1;
      tuse_rt = 2'd0;
    end else if (is_jr) begin
      use_rs  = 1'b1;
      tuse_rs = 2'd0;
    end else if (is_jal) begin
      dst_d   = 5'd31;
      tnew_d  = 2'd0;
    end else if (is_j) begin
      dst_d   = 5'd0;
    end
  end

  // ------------------------------------------------------------------
  // Shadow pipeline of register fields and remaining result latency
  // ------------------------------------------------------------------
  logic [4:0] e_rs;
  logic [4:0] e_rt;
  logic [4:0] e_dst;
  logic [1:0] e_tnew;
  logic [4:0] m_rt;
  logic [4:0] m_dst;
  logic [1:0] m_tnew;
  logic [4:0] w_dst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_rs   <= 5'd0;
      e_rt   <= 5'd0;
      e_dst  <= 5'd0;
      e_tnew <= 2'd0;
      m_rt   <= 5'd0;
      m_dst  <= 5'd0;
      m_tnew <= 2'd0;
      w_dst  <= 5'd0;
    end else begin
      if (stall) begin
        e_rs   <= 5'd0;
        e_rt   <= 5'd0;
        e_dst  <= 5'd0;
        e_tnew <= 2'd0;
      end else begin
        e_rs   <= rs_d;
        e_rt   <= rt_d;
        e_dst  <= dst_d;
        e_tnew <= tnew_d;
      end
      m_rt   <= e_rt;
      m_dst  <= e_dst;
      m_tnew <= (e_tnew != 2'd0) ? (e_tnew - 2'd1) : 2'd0;
      w_dst  <= m_dst;
    end
  end

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // ------------------------------------------------------------------
  // Stall: a used source whose producer cannot deliver in time
  // ------------------------------------------------------------------
  logic stall_rs;
  logic stall_rt;

  always_comb begin
    stall_rs = use_rs &&
               ((reg_match(rs_d, e_dst) && (e_tnew > tuse_rs)) ||
                (reg_match(rs_d, m_dst) && (m_tnew > tuse_rs)));
    stall_rt = use_rt &&
               ((reg_match(rt_d, e_dst) && (e_tnew > tuse_rt)) ||
                (reg_match(rt_d, m_dst) && (m_tnew > tuse_rt)));
    stall    = stall_rs || stall_rt;
  end

  // ------------------------------------------------------------------
  // Forward selects (independent of stall; the datapath ignores them
  // while the pipeline is frozen)
  // ------------------------------------------------------------------
  function automatic logic [1:0] sel_d(input logic [4:0] src);
    if (reg_match(src, e_dst) && (e_tnew == 2'd0))
      return 2'd1;
    else if (reg_match(src, m_dst) && (m_tnew == 2'd0))
      return 2'd2;
    else if (reg_match(src, w_dst))
      return 2'd3;
    else
      return 2'd0;
  endfunction

  function automatic logic [1:0] sel_e(input logic [4:0] src);
    if (reg_match(src, m_dst) && (m_tnew == 2'd0))
      return 2'd1;
    else if (reg_match(src, w_dst))
      return 2'd2;
    else
      return 2'd0;
  endfunction

  always_comb begin
    fwd_rs_d = sel_d(rs_d);
    fwd_rt_d = sel_d(rt_d);
    fwd_rs_e = sel_e(e_rs);
    fwd_rt_e = sel_e(e_rt);
    fwd_rt_m = reg_match(m_rt, w_dst);
  end

  // ------------------------------------------------------------------
  // Saturating stall statistics
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
